hazard_ctrl: RTL

Pipeline hazard controller for the 5-stage RV32 core; sits beside the fetch/decode/execute/memory/writeback stage blocks.
Keeps a shadow scoreboard of destination-register, write-enable and load flags for the E, M and W stages.
From that scoreboard it generates operand-forwarding selects for E, load-use stalls for F/D, and flushes for D/E on a taken branch.
Also sequences a post-reset flush window, so no stale pipeline-register content executes after reset release.

---
 rtl/pipe_pkg.sv | 15 +
 rtl/hazard_scoreboard.sv | 59 +++++
 rtl/hazard_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared encodings for the RV32 pipeline hazard controller
package pipe_pkg;

  localparam int REG_ADDR_W_DEF = 5;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_RF  = 2'b00;
  localparam fwd_sel_t FWD_WB  = 2'b01;
  localparam fwd_sel_t FWD_MEM = 2'b10;

  localparam logic [0:0] HZ_INIT = 1'b0;
  localparam logic [0:0] HZ_RUN  = 1'b1;

endpackage

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - E/M/W shadow of register addresses and write/load flags
module hazard_scoreboard
  import pipe_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_e_i,
  input  logic [REG_ADDR_W-1:0] rs1_d_i,
  input  logic [REG_ADDR_W-1:0] rs2_d_i,
  input  logic [REG_ADDR_W-1:0] rd_d_i,
  input  logic                  reg_write_d_i,
  input  logic                  result_src_d_i,
  output logic [REG_ADDR_W-1:0] rs1_e_o,
  output logic [REG_ADDR_W-1:0] rs2_e_o,
  output logic [REG_ADDR_W-1:0] rd_e_o,
  output logic                  reg_write_e_o,
  output logic                  result_src_e_o,
  output logic [REG_ADDR_W-1:0] rd_m_o,
  output logic                  reg_write_m_o,
  output logic [REG_ADDR_W-1:0] rd_w_o,
  output logic                  reg_write_w_o
);

  // A flushed E entry becomes an all-zero bubble; D-stage stalls never freeze E/M/W.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rs1_e_o        <= '0;
      rs2_e_o        <= '0;
      rd_e_o         <= '0;
      reg_write_e_o  <= 1'b0;
      result_src_e_o <= 1'b0;
      rd_m_o         <= '0;
      reg_write_m_o  <= 1'b0;
      rd_w_o         <= '0;
      reg_write_w_o  <= 1'b0;
    end else begin
      if (flush_e_i) begin
        rs1_e_o        <= '0;
        rs2_e_o        <= '0;
        rd_e_o         <= '0;
        reg_write_e_o  <= 1'b0;
        result_src_e_o <= 1'b0;
      end else begin
        rs1_e_o        <= rs1_d_i;
        rs2_e_o        <= rs2_d_i;
        rd_e_o         <= rd_d_i;
        reg_write_e_o  <= reg_write_d_i;
        result_src_e_o <= result_src_d_i;
      end
      rd_m_o        <= rd_e_o;
      reg_write_m_o <= reg_write_e_o;
      rd_w_o        <= rd_m_o;
      reg_write_w_o <= reg_write_m_o;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - forwarding, load-use stall, branch flush and startup flush sequencing
// Optional stall/flush performance counters under HAZARD_PERF_CNT_EN.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_ADDR_W    = REG_ADDR_W_DEF,
  parameter int STARTUP_FLUSH = 2,
  parameter int CNT_W         = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] RS1_D,
  input  logic [REG_ADDR_W-1:0] RS2_D,
  input  logic [REG_ADDR_W-1:0] RD_D,
  input  logic                  RegWriteD,
  input  logic                  ResultSrcD,
  input  logic                  PCSrcE,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  localparam logic [3:0] STARTUP_LAST = 4'(STARTUP_FLUSH - 1);

  logic [REG_ADDR_W-1:0] rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic                  reg_write_e, result_src_e, reg_write_m, reg_write_w;
  logic [0:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  lw_stall, stall, flush_e, flush_d;
  fwd_sel_t              fwd_a, fwd_b;

  hazard_scoreboard #(.REG_ADDR_W(REG_ADDR_W)) u_scoreboard (
    .clk            (clk),
    .rst            (rst),
    .flush_e_i      (flush_e),
    .rs1_d_i        (RS1_D),
    .rs2_d_i        (RS2_D),
    .rd_d_i         (RD_D),
    .reg_write_d_i  (RegWriteD),
    .result_src_d_i (ResultSrcD),
    .rs1_e_o        (rs1_e),
    .rs2_e_o        (rs2_e),
    .rd_e_o         (rd_e),
    .reg_write_e_o  (reg_write_e),
    .result_src_e_o (result_src_e),
    .rd_m_o         (rd_m),
    .reg_write_m_o  (reg_write_m),
    .rd_w_o         (rd_w),
    .reg_write_w_o  (reg_write_w)
  );

  always_comb begin
    fwd_a = FWD_RF;
    if (reg_write_m && (rd_m != '0) && (rd_m == rs1_e))      fwd_a = FWD_MEM;
    else if (reg_write_w && (rd_w != '0) && (rd_w == rs1_e)) fwd_a = FWD_WB;
    fwd_b = FWD_RF;
    if (reg_write_m && (rd_m != '0) && (rd_m == rs2_e))      fwd_b = FWD_MEM;
    else if (reg_write_w && (rd_w != '0) && (rd_w == rs2_e)) fwd_b = FWD_WB;
  end

  // rs2 is compared for every format; an occasional spurious I-type stall is harmless.
  assign lw_stall = result_src_e & reg_write_e & (rd_e != '0) &
                    ((rd_e == RS1_D) | (rd_e == RS2_D));

  always_comb begin
    stall   = 1'b0;
    flush_d = 1'b1;
    flush_e = 1'b1;
    if (state_q == HZ_RUN) begin
      stall   = lw_stall & ~PCSrcE;
      flush_d = PCSrcE;
      flush_e = lw_stall | PCSrcE;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == HZ_INIT) begin
      if (cnt_q == STARTUP_LAST) state_d = HZ_RUN;
      else                       cnt_d   = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= HZ_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign StallF    = stall;
  assign StallD    = stall;
  assign FlushD    = flush_d;
  assign FlushE    = flush_e;
  assign ForwardAE = fwd_a;
  assign ForwardBE = fwd_b;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (state_q == HZ_RUN) begin
      if (stall && (stall_cnt_q != '1))  stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (PCSrcE && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
